// File: rtl/spmv_result_packer.sv
// spmv_result_packer: requantizes four partial sums to saturated int8, packs them densely
// into 32-bit words and buffers the words in a small FIFO with a valid/ready output.
module spmv_result_packer #(
   parameter int k     = 4,
   parameter int ACC_W = 28,
   parameter int SHIFT = 8,
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ACC_W*k-1:0] psum_in,
   input  logic               psum_valid,
   input  logic [k-1:0]       lane_mask,
   input  logic               flush,
   output logic [8*k-1:0]     out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               in_ready,
   output logic               flush_done,
   output logic               overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [0:0] RUN = 1'b0;
   localparam logic [0:0] DRAIN = 1'b1;
   localparam logic [ACC_W:0] RND = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);

   logic [8*k-1:0] w_q, r_q, w_comp;
   logic [k-1:0]   r_mask;
   logic           r_flush;
   logic [23:0]    r_pbuf, w_rem;
   logic [1:0]     r_pcnt;
   logic [2:0]     w_n, w_tot, w_rcnt;
   logic [55:0]    w_stream;
   logic           w_pa, w_pb, w_pop, w_acc_a, w_acc_b;
   logic [31:0]    r_mem [DEPTH];
   logic [AW-1:0]  r_wp, r_rp, w_wp2;
   logic [AW:0]    r_cnt, w_free;
   logic [0:0]     r_state;
   logic           r_ovf;

   for (genvar g = 0; g < k; g++) begin : g_lane
      logic [ACC_W-1:0] w_s;
      logic [ACC_W:0]   w_sum, w_r;
      assign w_s   = psum_in[ACC_W*(k-g)-1 -: ACC_W];
      assign w_sum = {w_s[ACC_W-1], w_s} + RND;
      assign w_r   = $signed(w_sum) >>> SHIFT;
      // Saturate when the bits above the int8 range are not all copies of the sign.
      assign w_q[8*(k-g)-1 -: 8] = (!w_r[ACC_W] && |w_r[ACC_W-1:7]) ? 8'h7f :
                                   (w_r[ACC_W] && !(&w_r[ACC_W-1:7])) ? 8'h80 : w_r[7:0];
   end

   always_comb begin
      w_comp = '0;
      w_n = '0;
      for (int i = 0; i < k; i++)
         if (r_mask[k-1-i]) begin
            w_comp = w_comp | ({r_q[8*(k-i)-1 -: 8], 24'h0} >> {w_n, 3'b0});
            w_n = w_n + 3'd1;
         end
   end

   // Bytes past pack_cnt in pack_buf are kept zero so the OR-merge below is exact.
   assign w_tot    = {1'b0, r_pcnt} + w_n;
   assign w_stream = {r_pbuf, 32'h0} | ({w_comp, 24'h0} >> {r_pcnt, 3'b0});
   assign w_pa     = w_tot[2];
   assign w_rem    = w_pa ? w_stream[23:0] : w_stream[55:32];
   assign w_rcnt   = w_pa ? w_tot - 3'd4 : w_tot;
   assign w_pb     = r_flush && (w_rcnt != 3'd0);

   assign w_pop   = out_valid && out_ready;
   assign w_free  = (AW+1)'(DEPTH) - r_cnt + (AW+1)'(w_pop);
   assign w_acc_a = w_pa && (w_free != '0);
   assign w_acc_b = w_pb && (w_acc_a ? w_free >= (AW+1)'(2) : w_free != '0);
   assign w_wp2   = r_wp + AW'(w_acc_a);

   assign out_valid  = r_cnt != '0;
   assign out_data   = out_valid ? r_mem[r_rp] : '0;
   assign in_ready   = (w_free >= (AW+1)'(2)) && (r_state == RUN);
   assign flush_done = (r_state == DRAIN) && (r_cnt == '0);
   assign overflow   = r_ovf;

   always_ff @(posedge clk) begin
      if (w_acc_a) r_mem[r_wp] <= w_stream[55:24];
      if (w_acc_b) r_mem[w_wp2] <= {w_rem, 8'h0};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q     <= '0;
         r_mask  <= '0;
         r_flush <= 1'b0;
         r_pbuf  <= '0;
         r_pcnt  <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_cnt   <= '0;
         r_state <= RUN;
         r_ovf   <= 1'b0;
      end else begin
         r_q     <= psum_valid ? w_q : r_q;
         r_mask  <= psum_valid ? lane_mask : '0;
         r_flush <= flush;
         r_pbuf  <= r_flush ? '0 : w_rem;
         r_pcnt  <= r_flush ? 2'd0 : w_rcnt[1:0];
         r_wp    <= w_wp2 + AW'(w_acc_b);
         r_rp    <= r_rp + AW'(w_pop);
         r_cnt   <= r_cnt + (AW+1)'(w_acc_a) + (AW+1)'(w_acc_b) - (AW+1)'(w_pop);
         r_ovf   <= r_ovf || (w_pa && !w_acc_a) || (w_pb && !w_acc_b);
         r_state <= r_flush ? DRAIN : flush_done ? RUN : r_state;
      end
   end
endmodule

// File: tb/tb_spmv_result_packer.sv
// tb_spmv_result_packer: directed vectors and corner-case sequences for spmv_result_packer.
module tb_spmv_result_packer;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [111:0] psum_in = '0;
   logic         psum_valid = 1'b0;
   logic [3:0]   lane_mask = '0;
   logic         flush = 1'b0;
   logic [31:0]  out_data;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic         in_ready;
   logic         flush_done;
   logic         overflow;

   int checks = 0;
   int errors = 0;
   int fd = 0;
   int fd_words = 0;
   logic [31:0] got [$];

   typedef struct {
      logic [3:0]  mask;
      int          s0, s1, s2, s3;
      logic        fl;
      logic [31:0] exp;
   } vec_t;
   vec_t v [7];

   spmv_result_packer dut (
      .clk(clk), .rst(rst), .psum_in(psum_in), .psum_valid(psum_valid),
      .lane_mask(lane_mask), .flush(flush), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .in_ready(in_ready), .flush_done(flush_done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (rst) begin
         if (out_valid && out_ready) got.push_back(out_data);
         if (flush_done) begin
            fd++;
            fd_words = got.size();
         end
      end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [111:0] mk(int a, int b, int c, int d);
      return {a[27:0], b[27:0], c[27:0], d[27:0]};
   endfunction

   function automatic logic [31:0] gw(int i);
      return (got.size() > i) ? got[i] : 32'hDEADBEEF;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(logic [3:0] m, int a, int b, int c, int d, logic fl);
      psum_in = mk(a, b, c, d);
      lane_mask = m;
      psum_valid = 1'b1;
      flush = fl;
      tick();
      psum_valid = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      v[0] = '{4'hF, 256, 512, -256, 384, 1'b0, 32'h0102FF02};
      v[1] = '{4'hF, 40000, -40000, -384, 32512, 1'b0, 32'h7F80FF7F};
      v[2] = '{4'b1010, 256, 512, 768, 1024, 1'b1, 32'h01030000};
      v[3] = '{4'b0001, 0, 0, 0, -129, 1'b1, 32'hFF000000};
      v[4] = '{4'hF, 127, 128, -128, -129, 1'b0, 32'h000100FF};
      v[5] = '{4'hF, 134217727, -134217728, -32896, 32639, 1'b0, 32'h7F80807F};
      v[6] = '{4'b0110, 0, 300, -300, 0, 1'b1, 32'h01FF0000};

      // Reset
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset overflow", 32'(overflow), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset flush_done", 32'(flush_done), 32'd0);
      chk("reset out_data", out_data, 32'h0);

      // Table-driven single-beat vectors, each self-contained
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         beat(v[i].mask, v[i].s0, v[i].s1, v[i].s2, v[i].s3, v[i].fl);
         tick();
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("vec%0d out_data", i), out_data, v[i].exp);
         tick();
         chk($sformatf("vec%0d out_valid low", i), 32'(out_valid), 32'd0);
         chk($sformatf("vec%0d flush_done", i), 32'(flush_done), 32'(v[i].fl));
         tick();
         chk($sformatf("vec%0d flush_done low", i), 32'(flush_done), 32'd0);
      end

      // Packing across beats plus flush
      got.delete();
      fd = 0;
      fd_words = 0;
      beat(4'b1100, 256, 512, 0, 0, 1'b0);
      beat(4'b1110, 768, 1024, 1280, 0, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      repeat (6) tick();
      chk("pack words", 32'(got.size()), 32'd2);
      chk("pack word0", gw(0), 32'h01020304);
      chk("pack word1", gw(1), 32'h05000000);
      chk("pack flush_done count", 32'(fd), 32'd1);
      chk("pack flush_done after words", 32'(fd_words), 32'd2);

      // Full FIFO: simultaneous pop and push is not a drop
      got.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) beat(4'hF, (i+1)*256, (i+1)*256, (i+1)*256, (i+1)*256, 1'b0);
      chk("full in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      repeat (7) tick();
      chk("full overflow", 32'(overflow), 32'd0);
      chk("full words", 32'(got.size()), 32'd5);
      for (int i = 0; i < 5; i++) chk($sformatf("full word%0d", i), gw(i), 32'h01010101 * (i+1));

      // Overflow: fifth word dropped, sticky flag, in-order drain
      got.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         beat(4'hF, (i+1)*256, (i+1)*256, (i+1)*256, (i+1)*256, 1'b0);
         chk($sformatf("ovf in_ready%0d", i), 32'(in_ready), 32'(i <= 2));
      end
      repeat (2) tick();
      chk("ovf overflow", 32'(overflow), 32'd1);
      chk("ovf in_ready", 32'(in_ready), 32'd0);
      chk("ovf out_valid", 32'(out_valid), 32'd1);
      chk("ovf head", out_data, 32'h01010101);
      repeat (3) tick();
      chk("ovf head stable", out_data, 32'h01010101);
      out_ready = 1'b1;
      repeat (6) tick();
      chk("ovf words", 32'(got.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("ovf word%0d", i), gw(i), 32'h01010101 * (i+1));
      chk("ovf sticky", 32'(overflow), 32'd1);
      chk("ovf drained", 32'(out_valid), 32'd0);

      // Asynchronous reset with two words held and two bytes pending
      got.delete();
      out_ready = 1'b0;
      beat(4'hF, 256, 256, 256, 256, 1'b0);
      beat(4'hF, 512, 512, 512, 512, 1'b0);
      beat(4'b1100, 768, 768, 0, 0, 1'b0);
      tick();
      chk("ares out_valid before", 32'(out_valid), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("ares out_valid", 32'(out_valid), 32'd0);
      chk("ares overflow", 32'(overflow), 32'd0);
      chk("ares in_ready", 32'(in_ready), 32'd1);
      #2 rst = 1'b1;
      tick();
      out_ready = 1'b1;
      fd = 0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      repeat (5) tick();
      chk("ares flush words", 32'(got.size()), 32'd0);
      chk("ares flush_done count", 32'(fd), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
